// File: rtl/uds_stream_engine.sv
// Streaming up/down-sample engine: consumes a tile as a stream of ROWS x CH columns and
// emits 2x2/3x3 stride-2 max/avg pooled columns or 2x nearest-upsampled columns.
module uds_stream_engine #(
    parameter int DATA_W = 32,
    parameter int CH     = 8,
    parameter int ROWS   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 function_mode,
    input  logic [1:0]                 scale_factor,
    input  logic [ROWS*CH*DATA_W-1:0]  in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [2*ROWS*CH*DATA_W-1:0] out_data,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready
);
    localparam int HALF  = ROWS / 2;
    localparam int SW    = DATA_W + 4;
    localparam int RED_W = HALF * CH * SW;
    localparam int OUT_W = 2 * ROWS * CH * DATA_W;

    typedef enum logic [1:0] {ACCEPT, UP2, FLUSH} state_t;
    state_t state, state_next;

    logic             k_zero, k_odd;
    logic             up_q, avg_q, win3_q, up_last_q;
    logic             eff_up, eff_avg, eff_win3;
    logic             out_free, in_fire;
    logic             emit, emit_last, go_flush;
    logic [RED_W-1:0] prev1, prev2, cur_red, wx, wy, wz;
    logic [OUT_W-1:0] up_data, win_data, flush_data;

    // Vertical reduce keeps the full-precision sum (avg) or the max, so the
    // horizontal stage can finish the window without losing bits.
    function automatic logic [SW-1:0] vert(input logic [ROWS*CH*DATA_W-1:0] col,
                                           input int r, input int c,
                                           input logic avg, input logic win3);
        logic [SW-1:0] a, b, d, m;
        int r3;
        r3 = (2*r + 2 > ROWS - 1) ? ROWS - 1 : 2*r + 2;
        a  = SW'(col[(2*r*CH + c)*DATA_W +: DATA_W]);
        b  = SW'(col[((2*r + 1)*CH + c)*DATA_W +: DATA_W]);
        d  = win3 ? SW'(col[(r3*CH + c)*DATA_W +: DATA_W]) : '0;
        m  = (a > b) ? a : b;
        if (d > m) m = d;
        return avg ? a + b + d : m;
    endfunction

    function automatic logic [DATA_W-1:0] horiz(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                                input logic [SW-1:0] z,
                                                input logic avg, input logic win3);
        logic [SW-1:0] zz, s, m, q;
        zz = win3 ? z : '0;
        s  = x + y + zz;
        m  = (x > y) ? x : y;
        if (zz > m) m = zz;
        q  = win3 ? s / SW'(9) : (s >> 2);
        return DATA_W'(avg ? q : m);
    endfunction

    function automatic logic [OUT_W-1:0] build(input logic [RED_W-1:0] x, input logic [RED_W-1:0] y,
                                               input logic [RED_W-1:0] z,
                                               input logic avg, input logic win3);
        logic [OUT_W-1:0] o;
        o = '0;
        for (int i = 0; i < HALF*CH; i++)
            o[i*DATA_W +: DATA_W] = horiz(x[i*SW +: SW], y[i*SW +: SW], z[i*SW +: SW], avg, win3);
        return o;
    endfunction

    assign out_free = !out_valid || out_ready;
    assign in_ready = !rst && (state == ACCEPT) && out_free;
    assign in_fire  = in_valid && in_ready;

    // The first column of a tile uses the live mode inputs; later columns use the latched copy.
    assign eff_up   = k_zero ? function_mode[1] : up_q;
    assign eff_avg  = k_zero ? function_mode[0] : avg_q;
    assign eff_win3 = k_zero ? (scale_factor == 2'd1) : win3_q;

    always_comb begin
        cur_red = '0;
        for (int r = 0; r < HALF; r++)
            for (int c = 0; c < CH; c++)
                cur_red[(r*CH + c)*SW +: SW] = vert(in_data, r, c, eff_avg, eff_win3);
    end

    always_comb begin
        up_data = '0;
        for (int p = 0; p < 2*ROWS; p++)
            for (int c = 0; c < CH; c++)
                up_data[(p*CH + c)*DATA_W +: DATA_W] = in_data[((p/2)*CH + c)*DATA_W +: DATA_W];
    end

    // Window column selection; z is ignored by the 2x2 window.
    always_comb begin
        wx = prev2;
        wy = prev1;
        wz = cur_red;
        if (k_odd) begin
            wx = prev1;
            wy = cur_red;
        end else if (!eff_win3 || k_zero) begin
            wx = cur_red;
            wy = cur_red;
        end
        go_flush  = in_last && eff_win3 && !k_odd && !k_zero;
        emit      = eff_win3 ? ((!k_odd && !k_zero) || in_last) : (k_odd || in_last);
        emit_last = in_last && !go_flush;
    end

    assign win_data   = build(wx, wy, wz, eff_avg, eff_win3);
    assign flush_data = build(prev1, prev1, prev1, avg_q, win3_q);

    always_comb begin
        state_next = state;
        case (state)
            ACCEPT: begin
                if (in_fire && eff_up)        state_next = UP2;
                else if (in_fire && go_flush) state_next = FLUSH;
            end
            UP2, FLUSH: if (out_free) state_next = ACCEPT;
            default: state_next = ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCEPT;
            k_zero    <= 1'b1;
            k_odd     <= 1'b0;
            up_q      <= 1'b0;
            avg_q     <= 1'b0;
            win3_q    <= 1'b0;
            up_last_q <= 1'b0;
            prev1     <= '0;
            prev2     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_next;
            if (in_fire) begin
                if (k_zero) begin
                    up_q   <= function_mode[1];
                    avg_q  <= function_mode[0];
                    win3_q <= (scale_factor == 2'd1);
                end
                k_zero    <= in_last;
                k_odd     <= !in_last && !k_odd;
                up_last_q <= in_last;
                if (k_odd) prev2 <= prev1;
                prev1 <= cur_red;
            end
            // Drain by default; a reload below in the same cycle overrides it.
            if (out_free) out_valid <= 1'b0;
            case (state)
                ACCEPT: begin
                    if (in_fire && (eff_up || emit)) begin
                        out_valid <= 1'b1;
                        out_last  <= eff_up ? 1'b0 : emit_last;
                        out_data  <= eff_up ? up_data : win_data;
                    end
                end
                UP2: begin
                    if (out_free) begin
                        out_valid <= 1'b1;
                        out_last  <= up_last_q;
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                        out_data  <= flush_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uds_stream_engine.sv
// Scoreboard bench for uds_stream_engine (DATA_W=8, CH=1, ROWS=4): expected beats are
// queued as columns are driven and compared as the engine hands them downstream.
module tb_uds_stream_engine;
    localparam int DATA_W = 8;
    localparam int CH     = 1;
    localparam int ROWS   = 4;
    localparam int IN_W   = ROWS * CH * DATA_W;
    localparam int OUT_W  = 2 * IN_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       function_mode;
    logic [1:0]       scale_factor;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } beat_t;

    beat_t sb[$];
    beat_t mon_got, mon_exp;
    int    checks = 0;
    int    errors = 0;

    uds_stream_engine #(.DATA_W(DATA_W), .CH(CH), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .function_mode(function_mode), .scale_factor(scale_factor),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [IN_W-1:0] col4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [OUT_W-1:0] dn(input int a, input int b);
        return {48'd0, 8'(b), 8'(a)};
    endfunction

    function automatic logic [OUT_W-1:0] up(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(d), 8'(c), 8'(c), 8'(b), 8'(b), 8'(a), 8'(a)};
    endfunction

    task automatic expectBeat(input logic [OUT_W-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        sb.push_back(b);
    endtask

    // Drive one column and hold it until the engine takes it; returns at posedge+1.
    task automatic applyStimulus(input logic [IN_W-1:0] d, input logic last,
                                 input logic [1:0] fm, input logic [1:0] sf, output int stalls);
        stalls        = 0;
        in_data       = d;
        in_last       = last;
        function_mode = fm;
        scale_factor  = sf;
        in_valid      = 1'b1;
        @(negedge clk);
        while (!in_ready && stalls < 100) begin
            @(negedge clk);
            stalls++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout in_ready=%b required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain pending=%0d required=0", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Downstream monitor: every handed-off beat must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                checks++;
                mon_got.data = out_data;
                mon_got.last = out_last;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_beat data=%h last=%b required=none", out_data, out_last);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_got !== mon_exp)
                    begin
                        errors++;
                        $display("[TB] FAIL beat data=%h last=%b required data=%h last=%b",
                                 mon_got.data, mon_got.last, mon_exp.data, mon_exp.last);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready got=%b required=0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got=%b required=0", out_valid); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_last got=%b required=0", out_last); end
        checks++;
        if (out_data !== '0) begin errors++; $display("[TB] FAIL rst_out_data got=%h required=0", out_data); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_in_ready got=%b required=1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_2x2_max;
        int st;
        expectBeat(dn(5, 9), 1'b0);
        expectBeat(dn(7, 7), 1'b1);
        applyStimulus(col4(1, 5, 2, 8), 1'b0, 2'b00, 2'b00, st);
        applyStimulus(col4(3, 4, 9, 0), 1'b0, 2'b00, 2'b00, st);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL max2x2_latency out_valid=%b required=1", out_valid); end
        @(posedge clk);
        #1;
        applyStimulus(col4(7, 7, 7, 7), 1'b0, 2'b00, 2'b00, st);
        applyStimulus(col4(6, 1, 2, 3), 1'b1, 2'b00, 2'b00, st);
        waitDrain("max2x2");
    endtask

    task automatic test_2x2_avg;
        int st;
        expectBeat(dn(15, 15), 1'b0);
        expectBeat(dn(30, 30), 1'b1);
        applyStimulus(col4(10, 10, 10, 10), 1'b0, 2'b01, 2'b00, st);
        applyStimulus(col4(20, 20, 20, 20), 1'b0, 2'b01, 2'b00, st);
        applyStimulus(col4(30, 30, 30, 30), 1'b1, 2'b01, 2'b00, st);
        waitDrain("avg2x2");
    endtask

    task automatic test_3x3_avg_flush;
        int st;
        expectBeat(dn(18, 18), 1'b0);
        expectBeat(dn(27, 27), 1'b1);
        applyStimulus(col4(9, 9, 9, 9), 1'b0, 2'b01, 2'b01, st);
        applyStimulus(col4(18, 18, 18, 18), 1'b0, 2'b01, 2'b01, st);
        applyStimulus(col4(27, 27, 27, 27), 1'b1, 2'b01, 2'b01, st);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_ready got=%b required=0", in_ready); end
        @(posedge clk);
        #1;
        waitDrain("avg3x3_flush");
    endtask

    task automatic test_3x3_edges;
        int st;
        // odd-k last window with replicated bottom row
        expectBeat(dn(5, 9), 1'b1);
        applyStimulus(col4(1, 2, 3, 4), 1'b0, 2'b00, 2'b01, st);
        applyStimulus(col4(5, 0, 0, 9), 1'b1, 2'b00, 2'b01, st);
        waitDrain("max3x3_odd_last");
        // single-column tile emits directly, no flush beat
        expectBeat(dn(9, 63), 1'b1);
        applyStimulus(col4(9, 9, 9, 90), 1'b1, 2'b01, 2'b01, st);
        waitDrain("avg3x3_k0_last");
        // scale_factor 2 falls back to the 2x2 window
        expectBeat(dn(6, 14), 1'b1);
        applyStimulus(col4(4, 8, 12, 16), 1'b0, 2'b01, 2'b10, st);
        applyStimulus(col4(4, 8, 12, 16), 1'b1, 2'b01, 2'b10, st);
        waitDrain("scale2_as_2x2");
    endtask

    task automatic test_upsample_hold;
        int st;
        out_ready = 1'b0;
        expectBeat(up(1, 2, 3, 4), 1'b0);
        expectBeat(up(1, 2, 3, 4), 1'b1);
        applyStimulus(col4(1, 2, 3, 4), 1'b1, 2'b10, 2'b00, st);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== up(1, 2, 3, 4) || out_last !== 1'b0) begin
                errors++;
                $display("[TB] FAIL up_hold%0d valid=%b data=%h last=%b required valid=1 data=%h last=0",
                         i, out_valid, out_data, out_last, up(1, 2, 3, 4));
            end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL up_hold_in_ready got=%b required=0", in_ready); end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitDrain("upsample");
    endtask

    task automatic test_mode_change;
        int st;
        expectBeat(dn(5, 9), 1'b0);
        expectBeat(dn(7, 7), 1'b1);
        applyStimulus(col4(1, 5, 2, 8), 1'b0, 2'b00, 2'b00, st);
        applyStimulus(col4(3, 4, 9, 0), 1'b0, 2'b00, 2'b00, st);
        applyStimulus(col4(7, 7, 7, 7), 1'b0, 2'b11, 2'b01, st);
        applyStimulus(col4(6, 1, 2, 3), 1'b1, 2'b11, 2'b01, st);
        waitDrain("mode_change");
    endtask

    task automatic test_back_to_back;
        int st;
        int total = 0;
        expectBeat(dn(4, 12), 1'b0);
        expectBeat(dn(255, 254), 1'b1);
        applyStimulus(col4(4, 8, 12, 16), 1'b0, 2'b01, 2'b00, st);
        total += st;
        applyStimulus(col4(0, 4, 8, 12), 1'b0, 2'b01, 2'b00, st);
        total += st;
        applyStimulus(col4(255, 255, 255, 255), 1'b0, 2'b01, 2'b00, st);
        total += st;
        applyStimulus(col4(255, 255, 255, 253), 1'b1, 2'b01, 2'b00, st);
        total += st;
        checks++;
        if (total != 0) begin errors++; $display("[TB] FAIL b2b_stalls got=%0d required=0", total); end
        waitDrain("back_to_back");
    endtask

    task automatic test_reset_mid_tile;
        int st;
        expectBeat(dn(2, 2), 1'b0);
        applyStimulus(col4(1, 1, 1, 1), 1'b0, 2'b00, 2'b00, st);
        applyStimulus(col4(2, 2, 2, 2), 1'b0, 2'b00, 2'b00, st);
        applyStimulus(col4(50, 50, 50, 50), 1'b0, 2'b00, 2'b00, st);
        in_data  = col4(60, 60, 60, 60);
        in_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_in_ready got=%b required=0", in_ready); end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid got=%b required=0", out_valid); end
        @(posedge clk);
        #1;
        expectBeat(dn(8, 6), 1'b1);
        applyStimulus(col4(1, 2, 3, 4), 1'b0, 2'b00, 2'b00, st);
        applyStimulus(col4(8, 7, 6, 5), 1'b1, 2'b00, 2'b00, st);
        waitDrain("reset_mid_tile");
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_last       = 1'b0;
        in_data       = '0;
        function_mode = 2'b00;
        scale_factor  = 2'b00;
        out_ready     = 1'b1;
        test_reset;
        test_2x2_max;
        test_2x2_avg;
        test_3x3_avg_flush;
        test_3x3_edges;
        test_upsample_hold;
        test_mode_change;
        test_back_to_back;
        test_reset_mid_tile;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
